// File: rtl/dwt_pkg.sv
// Shared types for the row-direction DWT front end.
//   row_pair_state_e : pairing phase (EVEN = waiting for even sample, ODD = even held)
//   pair_t           : default-width pair payload {eol, sof, even, odd}
package dwt_pkg;

  localparam int unsigned DWT_DATA_W = 16;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } row_pair_state_e;

  typedef struct packed {
    logic                         eol;
    logic                         sof;
    logic signed [DWT_DATA_W-1:0] even;
    logic signed [DWT_DATA_W-1:0] odd;
  } pair_t;

endpackage

// File: rtl/row_pair_out_reg.sv
// Single-entry valid/ready output register holding one pair payload.
// Ports:
//   clk_i, rst_i  : clock, async active-low reset
//   i_load        : new pair to capture (only honoured when the slot is free)
//   i_pair        : pair payload
//   i_ready       : downstream ready
//   o_valid       : slot holds a pair
//   o_pair        : held pair (cleared to 0 by reset)
module row_pair_out_reg
  import dwt_pkg::*;
#(
  parameter type pair_type_t = pair_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       i_load,
  input  pair_type_t i_pair,
  input  logic       i_ready,
  output logic       o_valid,
  output pair_type_t o_pair
);

  logic       r_valid;
  pair_type_t r_pair;

  // Slot refills or drains whenever it is empty or being consumed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_pair  <= '0;
    end else if (!r_valid || i_ready) begin
      r_valid <= i_load;
      if (i_load) r_pair <= i_pair;
    end
  end

  assign o_valid = r_valid;
  assign o_pair  = r_pair;

endmodule

// File: rtl/row_pair_packer.sv
// Repacks a line-framed scalar sample stream into {odd, even} pairs, mirroring
// the last sample of odd-length lines (odd = x[N-2]) so every line ends on a
// complete pair. Resyncs on an unexpected sof and pulses err_o.
// Optional macro ROW_PAIR_LEN_CHECK_EN: lines reaching MaximumSideSize samples
// without eol get a forced eol and an err_o pulse.
// Ports:
//   clk_i, rst_i                               : clock, async active-low reset
//   s_valid_i/s_ready_o/s_sof_i/s_eol_i/s_data_i : sample input stream
//   m_valid_o/m_ready_i/m_sof_o/m_eol_o/m_data_o : pair output stream, data {odd, even}
//   err_o                                      : one-cycle framing error pulse
module row_pair_packer
  import dwt_pkg::*;
#(
  parameter int unsigned DataWidth       = DWT_DATA_W,
  parameter int unsigned MaximumSideSize = 512
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [DataWidth-1:0]   s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o,
  output logic                   err_o
);

  typedef struct packed {
    logic                 eol;
    logic                 sof;
    logic [DataWidth-1:0] even;
    logic [DataWidth-1:0] odd;
  } pair_w_t;

  if ((MaximumSideSize < 2) || ((MaximumSideSize % 2) != 0)) begin : g_bad_size
    $error("MaximumSideSize must be even and at least 2");
  end

  row_pair_state_e      r_state, w_state_nxt;
  logic [DataWidth-1:0] r_even, w_even_nxt;
  logic [DataWidth-1:0] r_last_odd, w_last_odd_nxt;
  logic                 r_sof, w_sof_nxt;
  logic                 r_has_odd, w_has_odd_nxt;
  logic                 r_err;
  logic                 w_acc, w_force, w_eol_eff, w_load, w_err;
  pair_w_t              w_pair, w_out_pair;

  // Ready depends only on the output slot, never on s_valid_i.
  assign s_ready_o = rst_i & (!m_valid_o | m_ready_i);
  assign w_acc     = s_valid_i & s_ready_o;

`ifdef ROW_PAIR_LEN_CHECK_EN
  localparam int unsigned CntW = $clog2(MaximumSideSize) + 1;

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_inc;

  // A sof sample always starts a fresh count of 1.
  assign w_cnt_inc = (s_sof_i ? CntW'(0) : r_cnt) + CntW'(1);
  assign w_force   = !s_eol_i && (w_cnt_inc == CntW'(MaximumSideSize));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)     r_cnt <= '0;
    else if (w_acc) r_cnt <= (s_eol_i || w_force) ? CntW'(0) : w_cnt_inc;
  end
`else
  assign w_force = 1'b0;
`endif

  assign w_eol_eff = s_eol_i | w_force;

  // Pairing decision for the accepted sample.
  always_comb begin
    w_state_nxt    = r_state;
    w_even_nxt     = r_even;
    w_sof_nxt      = r_sof;
    w_last_odd_nxt = r_last_odd;
    w_has_odd_nxt  = r_has_odd;
    w_load         = 1'b0;
    w_pair         = '0;
    w_err          = w_acc & w_force;
    if (w_acc) begin
      case (r_state)
        EVEN: begin
          if (w_eol_eff) begin
            // Odd-length line: mirror x[N-2], or duplicate a lone sample.
            w_load        = 1'b1;
            w_pair.even   = s_data_i;
            w_pair.odd    = (r_has_odd && !s_sof_i) ? r_last_odd : s_data_i;
            w_pair.sof    = s_sof_i;
            w_pair.eol    = 1'b1;
            w_has_odd_nxt = 1'b0;
          end else begin
            w_even_nxt  = s_data_i;
            w_sof_nxt   = s_sof_i;
            w_state_nxt = ODD;
            if (s_sof_i) w_has_odd_nxt = 1'b0;
          end
        end
        ODD: begin
          if (s_sof_i) begin
            // Resync: drop the held even sample and restart the line here.
            w_err         = 1'b1;
            w_has_odd_nxt = 1'b0;
            if (w_eol_eff) begin
              w_load      = 1'b1;
              w_pair.even = s_data_i;
              w_pair.odd  = s_data_i;
              w_pair.sof  = 1'b1;
              w_pair.eol  = 1'b1;
              w_state_nxt = EVEN;
            end else begin
              w_even_nxt = s_data_i;
              w_sof_nxt  = 1'b1;
            end
          end else begin
            w_load         = 1'b1;
            w_pair.even    = r_even;
            w_pair.odd     = s_data_i;
            w_pair.sof     = r_sof;
            w_pair.eol     = w_eol_eff;
            w_last_odd_nxt = s_data_i;
            w_has_odd_nxt  = !w_eol_eff;
            w_state_nxt    = EVEN;
          end
        end
        default: w_state_nxt = EVEN;
      endcase
    end
  end

  // Pairing state and error pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= EVEN;
      r_even     <= '0;
      r_last_odd <= '0;
      r_sof      <= 1'b0;
      r_has_odd  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_even     <= w_even_nxt;
      r_last_odd <= w_last_odd_nxt;
      r_sof      <= w_sof_nxt;
      r_has_odd  <= w_has_odd_nxt;
      r_err      <= w_err;
    end
  end

  row_pair_out_reg #(
    .pair_type_t(pair_w_t)
  ) u_out_reg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_load (w_load),
    .i_pair (w_pair),
    .i_ready(m_ready_i),
    .o_valid(m_valid_o),
    .o_pair (w_out_pair)
  );

  assign m_sof_o  = w_out_pair.sof;
  assign m_eol_o  = w_out_pair.eol;
  assign m_data_o = {w_out_pair.odd, w_out_pair.even};
  assign err_o    = r_err;

endmodule

// File: tb/tb_row_pair_packer.sv
// Randomized and directed bench for row_pair_packer with a line-level model.
module tb_row_pair_packer;

  localparam int unsigned DW  = 16;
  localparam int unsigned MAX = 8;
`ifdef ROW_PAIR_LEN_CHECK_EN
  localparam bit LenChk = 1'b1;
`else
  localparam bit LenChk = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic          s_ready_o, s_valid_i, s_sof_i, s_eol_i;
  logic [DW-1:0] s_data_i;
  logic          m_ready_i, m_valid_o, m_sof_o, m_eol_o, err_o;
  logic [2*DW-1:0] m_data_o;

  row_pair_packer #(.DataWidth(DW), .MaximumSideSize(MAX)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_ready_o(s_ready_o), .s_valid_i(s_valid_i), .s_sof_i(s_sof_i),
    .s_eol_i(s_eol_i), .s_data_i(s_data_i),
    .m_ready_i(m_ready_i), .m_valid_o(m_valid_o), .m_sof_o(m_sof_o),
    .m_eol_o(m_eol_o), .m_data_o(m_data_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rx  = 0;
  int n_err = 0;
  int stall = 0;
  bit rand_mr = 1'b0;
  bit exp_err = 1'b0;

  // Expected pairs packed as {sof, eol, odd, even}.
  logic [2*DW+1:0] q[$];
  logic [2*DW+1:0] hist[$];
  // Samples of the currently open line.
  logic [DW-1:0]   cur[$];
  bit              line_sof = 1'b0;

  function automatic logic [2*DW+1:0] mk(input logic [DW-1:0] odd, input logic [DW-1:0] even,
                                         input logic sof, input logic eol);
    return {sof, eol, odd, even};
  endfunction

  task automatic chk(input string name, input logic [2*DW+1:0] act, input logic [2*DW+1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic emit(input logic [2*DW+1:0] p);
    q.push_back(p);
    hist.push_back(p);
  endtask

  // Line-level model: pairs are indexed by position inside the current line.
  task automatic model_accept(input logic [DW-1:0] d, input bit sof, input bit eol);
    int idx;
    bit eol_eff;
    if (sof) begin
      if (cur.size() % 2 == 1) begin exp_err = 1'b1; n_err++; end
      cur.delete();
      line_sof = 1'b1;
    end else if (cur.size() == 0) begin
      line_sof = 1'b0;
    end
    cur.push_back(d);
    idx = cur.size() - 1;
    eol_eff = eol;
    if (LenChk && !eol && cur.size() == MAX) begin
      eol_eff = 1'b1;
      exp_err = 1'b1;
      n_err++;
    end
    if (idx % 2 == 1)
      emit(mk(cur[idx], cur[idx-1], line_sof && idx == 1, eol_eff));
    else if (eol_eff)
      emit(mk((idx == 0) ? d : cur[idx-1], d, line_sof && idx == 0, 1'b1));
    if (eol_eff) cur.delete();
  endtask

  // One clock: check outputs of the last edge, drive new inputs, advance model.
  task automatic cycle(input bit v, input bit sof, input bit eol, input logic [DW-1:0] d,
                       output bit acc);
    bit mr, exp_v, exp_rdy;
    @(negedge clk);
    exp_v = (q.size() != 0);
    chk("m_valid", {33'd0, m_valid_o}, {33'd0, exp_v});
    if (exp_v) chk("m_pair", {m_sof_o, m_eol_o, m_data_o}, q[0]);
    chk("err", {33'd0, err_o}, {33'd0, exp_err});
    if (stall > 0) begin mr = 1'b0; stall--; end
    else if (rand_mr) mr = ($urandom_range(3) != 0);
    else mr = 1'b1;
    s_valid_i = v; s_sof_i = sof; s_eol_i = eol; s_data_i = d; m_ready_i = mr;
    #1;
    exp_rdy = !exp_v || mr;
    chk("s_ready", {33'd0, s_ready_o}, {33'd0, exp_rdy});
    acc = v && exp_rdy;
    if (exp_v && mr) begin void'(q.pop_front()); n_rx++; end
    exp_err = 1'b0;
    if (acc) model_accept(d, sof, eol);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit sof, input bit eol);
    bit acc;
    int tries = 0;
    do begin
      cycle(1'b1, sof, eol, d, acc);
      tries++;
    end while (!acc && tries < 64);
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: sample %0d not accepted after %0d cycles", d, tries);
    end
  endtask

  task automatic idle();
    bit acc;
    cycle(1'b0, 1'b0, 1'b0, '0, acc);
  endtask

  task automatic drain();
    rand_mr = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) idle();
    idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, {33'd0, m_valid_o}, '0);
    chk({tag, "_m_sof"},   {33'd0, m_sof_o},   '0);
    chk({tag, "_m_eol"},   {33'd0, m_eol_o},   '0);
    chk({tag, "_m_data"},  {2'd0, m_data_o},   '0);
    chk({tag, "_err"},     {33'd0, err_o},     '0);
    chk({tag, "_s_ready"}, {33'd0, s_ready_o}, '0);
  endtask

  initial begin
    int b, e0, rx0;
    rst_i = 1'b0; s_valid_i = 1'b0; s_sof_i = 1'b0; s_eol_i = 1'b0;
    s_data_i = '0; m_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_i = 1'b1;

    // Even-length line.
    b = hist.size(); e0 = n_err;
    send(16'd1, 1, 0); send(16'd2, 0, 0); send(16'd3, 0, 0); send(16'd4, 0, 1);
    drain();
    chk("t1_pair0", hist[b],   mk(16'd2, 16'd1, 1, 0));
    chk("t1_pair1", hist[b+1], mk(16'd4, 16'd3, 0, 1));
    chk("t1_errs", 34'(n_err - e0), 34'd0);

    // Odd-length line with mirror.
    b = hist.size();
    send(16'd10, 1, 0); send(16'd20, 0, 0); send(16'd30, 0, 0);
    send(16'd40, 0, 0); send(16'd50, 0, 1);
    drain();
    chk("t2_pair0", hist[b],   mk(16'd20, 16'd10, 1, 0));
    chk("t2_pair1", hist[b+1], mk(16'd40, 16'd30, 0, 0));
    chk("t2_pair2", hist[b+2], mk(16'd40, 16'd50, 0, 1));

    // Single-sample line.
    b = hist.size();
    send(16'd7, 1, 1);
    drain();
    chk("t3_pair", hist[b], mk(16'd7, 16'd7, 1, 1));
    chk("t3_count", 34'(hist.size() - b), 34'd1);

    // Output stall after the second pair.
    b = hist.size(); rx0 = n_rx;
    send(16'd1, 1, 0); send(16'd2, 0, 0); send(16'd3, 0, 0); send(16'd4, 0, 0);
    stall = 5;
    send(16'd5, 0, 0); send(16'd6, 0, 0); send(16'd7, 0, 0); send(16'd8, 0, 1);
    drain();
    chk("t4_pair1", hist[b+1], mk(16'd4, 16'd3, 0, 0));
    chk("t4_pair3", hist[b+3], mk(16'd8, 16'd7, 0, 1));
    chk("t4_delivered", 34'(n_rx - rx0), 34'd4);

    // Resync on a second sof.
    b = hist.size(); e0 = n_err;
    send(16'd1, 1, 0); send(16'd2, 1, 0); send(16'd3, 0, 1);
    drain();
    chk("t5_pair", hist[b], mk(16'd3, 16'd2, 1, 1));
    chk("t5_errs", 34'(n_err - e0), 34'd1);

    // Ten samples without eol.
    b = hist.size(); e0 = n_err;
    for (int i = 1; i <= 10; i++) send(DW'(i), i == 1, 0);
    drain();
    chk("t6_pair3", hist[b+3], mk(16'd8, 16'd7, 0, LenChk));
    chk("t6_pair4", hist[b+4], mk(16'd10, 16'd9, 0, 0));
    chk("t6_errs", 34'(n_err - e0), 34'(LenChk));

    // Reset mid-pair with a pending output.
    stall = 3;
    send(16'd11, 1, 0); send(16'd12, 0, 0); send(16'd13, 0, 0);
    @(negedge clk);
    rst_i = 1'b0; s_valid_i = 1'b0;
    #1 check_reset_outputs("midreset");
    q.delete(); cur.delete(); exp_err = 1'b0; stall = 0; line_sof = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    b = hist.size();
    idle();
    send(16'd9, 0, 0); send(16'd8, 0, 1);
    drain();
    chk("t7_pair", hist[b], mk(16'd8, 16'd9, 0, 1));

    // Random lines with gaps, backpressure and stray sof.
    rand_mr = 1'b1;
    for (int ln = 0; ln < 250; ln++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        bit sof, eol;
        sof = (k == 0) ? ($urandom_range(9) != 0) : ($urandom_range(24) == 0);
        eol = (k == len - 1) && ($urandom_range(19) != 0);
        if ($urandom_range(3) == 0) idle();
        send(DW'($urandom), sof, eol);
      end
      rand_mr = 1'b1;
    end
    drain();
    chk("final_empty", 34'(q.size()), 34'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
